maxnet_core: RTL

- Iterative Maxnet winner-take-all engine.
- Captures N neuron activations and repeatedly applies lateral inhibition until at most one neuron stays non-zero.
- Then presents the winner index, value and iteration count, and pulses a load strobe into the downstream result registers (ld-enabled, clk/rst registers).
- Sits directly upstream of those result registers; consumes the input-vector register bank.

---
 rtl/maxnet_core.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/maxnet_core.sv
// maxnet_core: iterative Maxnet winner-take-all engine.
//
// Captures N signed activations (negatives clamp to zero) plus an unsigned
// Q.FRAC inhibition weight, then applies lateral inhibition once per cycle
// until at most one neuron stays non-zero. The winner index, value and
// iteration count are presented together with a one-cycle done / ld_out
// strobe that loads the downstream result registers.
//
// Optional feature (macro MAXNET_TIMEOUT_EN): caps the run at MAX_ITER
// iterations. On the cap, timeout is raised and the lowest-index maximum
// activation is reported. Without the macro, timeout is tied to 0.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start       begin a competition (honoured only when idle)
//   x_in        N packed signed activations, neuron i at [i*XLEN +: XLEN]
//   eps         inhibition weight, unsigned Q.FRAC, sampled with start
//   busy        high from the cycle after start until the done cycle
//   done        one-cycle completion pulse
//   ld_out      copy of done, load enable for the result registers
//   winner_idx  index of the surviving neuron
//   winner_val  final activation of that neuron
//   no_winner   every activation reached zero
//   iter_count  number of inhibition iterations performed
//   timeout     iteration cap reached (feature build only)

module maxnet_core #(
    parameter int unsigned N        = 4,
    parameter int unsigned XLEN     = 16,
    parameter int unsigned FRAC     = 8,
    parameter int unsigned MAX_ITER = 255,
    parameter int unsigned CW       = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [N*XLEN-1:0]                   x_in,
    input  logic [XLEN-1:0]                     eps,
    output logic                                busy,
    output logic                                done,
    output logic                                ld_out,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] winner_idx,
    output logic [XLEN-1:0]                     winner_val,
    output logic                                no_winner,
    output logic [CW-1:0]                       iter_count,
    output logic                                timeout
);

    localparam int unsigned IW   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SW   = XLEN + $clog2(N);   // sum of all activations
    localparam int unsigned PW   = XLEN + SW;          // full eps * partial-sum product
    localparam int unsigned CNTW = $clog2(N + 1);      // non-zero neuron count

    typedef enum logic [1:0] {StIdle, StLoad, StIter, StDone} state_e;

    state_e          state;
    logic [XLEN-1:0] act [N];
    logic [XLEN-1:0] eps_q;

    // ------------------------------------------------------------------
    // Input clamp: negative activations enter the network as zero.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] clamped [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            clamped[i] = x_in[i*XLEN + XLEN - 1] ? '0 : x_in[i*XLEN +: XLEN];
        end
    end

    // ------------------------------------------------------------------
    // One inhibition step computed from the current activations.
    // ------------------------------------------------------------------
    logic [SW-1:0]   sum;
    logic [SW-1:0]   others [N];
    logic [PW-1:0]   inh    [N];
    logic [XLEN-1:0] act_nxt [N];

    always_comb begin
        sum = '0;
        for (int i = 0; i < N; i++) begin
            sum = sum + SW'(act[i]);
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            others[i] = sum - SW'(act[i]);
            inh[i]    = (PW'(eps_q) * PW'(others[i])) >> FRAC;
            // When act > inh the inhibition fits in XLEN bits, so the slice is exact.
            act_nxt[i] = (PW'(act[i]) > inh[i]) ? (act[i] - inh[i][XLEN-1:0]) : '0;
        end
    end

    // ------------------------------------------------------------------
    // Non-zero counts for the current and the next activations.
    // ------------------------------------------------------------------
    logic [CNTW-1:0] nz_cur;
    logic [CNTW-1:0] nz_nxt;

    always_comb begin
        nz_cur = '0;
        nz_nxt = '0;
        for (int i = 0; i < N; i++) begin
            nz_cur = nz_cur + CNTW'(act[i] != '0);
            nz_nxt = nz_nxt + CNTW'(act_nxt[i] != '0);
        end
    end

    // ------------------------------------------------------------------
    // Lowest-index maximum. With a single survivor this is the survivor;
    // with none it is index 0 / value 0; after a timeout it is the leader.
    // ------------------------------------------------------------------
    logic [IW-1:0]   max_idx;
    logic [XLEN-1:0] max_val;

    always_comb begin
        max_idx = '0;
        max_val = act[0];
        for (int i = 1; i < N; i++) begin
            if (act[i] > max_val) begin
                max_val = act[i];
                max_idx = IW'(i);
            end
        end
    end

    logic [CW-1:0] iter_inc;
    assign iter_inc = iter_count + CW'(1);

`ifdef MAXNET_TIMEOUT_EN
    localparam logic [CW-1:0] IterCap = CW'(MAX_ITER);
`else
    logic [CW-1:0] unused_max_iter;
    assign unused_max_iter = CW'(MAX_ITER);
    assign timeout         = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Control FSM with registered outputs. The done strobe is issued on
    // the edge that leaves StDone, so it coincides with the return to idle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            busy       <= 1'b0;
            done       <= 1'b0;
            ld_out     <= 1'b0;
            winner_idx <= '0;
            winner_val <= '0;
            no_winner  <= 1'b0;
            iter_count <= '0;
            eps_q      <= '0;
            for (int i = 0; i < N; i++) begin
                act[i] <= '0;
            end
`ifdef MAXNET_TIMEOUT_EN
            timeout    <= 1'b0;
`endif
        end else begin
            done   <= 1'b0;
            ld_out <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        for (int i = 0; i < N; i++) begin
                            act[i] <= clamped[i];
                        end
                        eps_q      <= eps;
                        iter_count <= '0;
                        no_winner  <= 1'b0;
                        busy       <= 1'b1;
`ifdef MAXNET_TIMEOUT_EN
                        timeout    <= 1'b0;
`endif
                        state      <= StLoad;
                    end
                end
                StLoad: begin
                    state <= (nz_cur <= CNTW'(1)) ? StDone : StIter;
                end
                StIter: begin
                    for (int i = 0; i < N; i++) begin
                        act[i] <= act_nxt[i];
                    end
                    iter_count <= iter_inc;
                    if (nz_nxt <= CNTW'(1)) begin
                        state <= StDone;
                    end
`ifdef MAXNET_TIMEOUT_EN
                    else if (iter_inc == IterCap) begin
                        timeout <= 1'b1;
                        state   <= StDone;
                    end
`endif
                end
                StDone: begin
                    done       <= 1'b1;
                    ld_out     <= 1'b1;
                    busy       <= 1'b0;
                    winner_idx <= max_idx;
                    winner_val <= max_val;
                    no_winner  <= (nz_cur == '0);
                    state      <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
